// File: rtl/n101_async_reset_reg_bank.sv
// Shadow/committed register pair with masked write/set/clear/toggle updates and explicit commit.
// Optional committed-value parity with error injection: define N101_REGBANK_PARITY_EN.
module n101_async_reset_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic [1:0]       io_op,
    input  logic [WIDTH-1:0] io_d,
    input  logic [WIDTH-1:0] io_wmask,
    input  logic             io_commit,
`ifdef N101_REGBANK_PARITY_EN
    input  logic             io_perr_inj,
    output logic             io_perr,
`endif
    output logic [WIDTH-1:0] io_q,
    output logic [WIDTH-1:0] io_shadow,
    output logic             io_pending,
    output logic             io_changed
);

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] commit_q, commit_d;
    logic             pending_q, pending_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] upd;
    logic             do_commit;

    always_comb begin
        upd = io_d;
        case (op_e'(io_op))
            OP_SET:    upd = shadow_q | io_d;
            OP_CLEAR:  upd = shadow_q & ~io_d;
            OP_TOGGLE: upd = shadow_q ^ io_d;
            default:   upd = io_d;
        endcase
    end

    // A commit without a pending update is ignored entirely; the committed
    // register always takes the pre-update shadow when both land together.
    always_comb begin
        do_commit = io_commit && pending_q;
        shadow_d  = io_en ? ((upd & io_wmask) | (shadow_q & ~io_wmask)) : shadow_q;
        commit_d  = do_commit ? shadow_q : commit_q;
        changed_d = do_commit && (shadow_q != commit_q);
        pending_d = pending_q;
        if (io_en)
            pending_d = 1'b1;
        else if (do_commit)
            pending_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q  <= RESET_VAL;
            commit_q  <= RESET_VAL;
            pending_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            commit_q  <= commit_d;
            pending_q <= pending_d;
            changed_q <= changed_d;
        end
    end

`ifdef N101_REGBANK_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = do_commit ? ((^shadow_q) ^ io_perr_inj) : parity_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            parity_q <= ^RESET_VAL;
        else
            parity_q <= parity_d;
    end

    assign io_perr = (^commit_q) ^ parity_q;
`endif

    assign io_q       = commit_q;
    assign io_shadow  = shadow_q;
    assign io_pending = pending_q;
    assign io_changed = changed_q;

endmodule

// File: tb/tb_n101_async_reset_reg_bank.sv
// Scoreboard bench for n101_async_reset_reg_bank (WIDTH=8, RESET_VAL=8'hA5).
// Define N101_REGBANK_PARITY_EN to also exercise the parity path.
module tb_n101_async_reset_reg_bank;

    localparam logic [7:0] RV = 8'hA5;
    localparam logic [1:0] WR = 2'b00, ST = 2'b01, CL = 2'b10, TG = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_en = 1'b0;
    logic [1:0] io_op = 2'b00;
    logic [7:0] io_d = 8'h00;
    logic [7:0] io_wmask = 8'h00;
    logic       io_commit = 1'b0;
    logic [7:0] io_q, io_shadow;
    logic       io_pending, io_changed;
`ifdef N101_REGBANK_PARITY_EN
    logic       io_perr_inj = 1'b0;
    logic       io_perr;
`endif

    typedef struct {
        logic [7:0] q;
        logic [7:0] sh;
        logic       p;
        logic       c;
    } obs_t;

    obs_t sb[$];
    obs_t ob[$];
    int   n_vec = 0;
    int   n_err = 0;

    n101_async_reset_reg_bank #(.WIDTH(8), .RESET_VAL(RV)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_en      (io_en),
        .io_op      (io_op),
        .io_d       (io_d),
        .io_wmask   (io_wmask),
        .io_commit  (io_commit),
`ifdef N101_REGBANK_PARITY_EN
        .io_perr_inj(io_perr_inj),
        .io_perr    (io_perr),
`endif
        .io_q       (io_q),
        .io_shadow  (io_shadow),
        .io_pending (io_pending),
        .io_changed (io_changed)
    );

    always #5 clock = ~clock;

    function automatic obs_t sample();
        obs_t o;
        o.q = io_q; o.sh = io_shadow; o.p = io_pending; o.c = io_changed;
        return o;
    endfunction

    // Drive one cycle, queue its expectation, capture what the DUT shows after the edge.
    task automatic apply(input logic en, input logic [1:0] op, input logic [7:0] d,
                         input logic [7:0] m, input logic cm,
                         input logic [7:0] eq, input logic [7:0] esh,
                         input logic ep, input logic ec);
        obs_t e;
        io_en = en; io_op = op; io_d = d; io_wmask = m; io_commit = cm;
        e.q = eq; e.sh = esh; e.p = ep; e.c = ec;
        sb.push_back(e);
        @(posedge clock);
        #1;
        ob.push_back(sample());
        io_en = 1'b0; io_commit = 1'b0;
    endtask

    // Assert reset away from any clock edge and capture outputs before the next edge.
    task automatic mid_reset(input bit release_now);
        obs_t e;
        @(negedge clock);
        #2 reset = 1'b1;
        e.q = RV; e.sh = RV; e.p = 1'b0; e.c = 1'b0;
        sb.push_back(e);
        #1 ob.push_back(sample());
        if (release_now) #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        int i = 0;
        apply(0, WR, 8'h00, 8'h00, 0, RV, RV, 0, 0);
        apply(1, WR, 8'h5A, 8'hFF, 0, RV, 8'h5A, 1, 0);
        apply(0, WR, 8'h00, 8'h00, 1, 8'h5A, 8'h5A, 0, 1);
        mid_reset(0);
        @(negedge clock);
        reset = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o.q !== e.q || o.sh !== e.sh || o.p !== e.p || o.c !== e.c) begin
                n_err++;
                $display("FAIL reset[%0d]: got q=%h sh=%h p=%b c=%b, want q=%h sh=%h p=%b c=%b",
                         i, o.q, o.sh, o.p, o.c, e.q, e.sh, e.p, e.c);
            end
            i++;
        end
    endtask

    task automatic test_ops();
        obs_t e, o;
        int i = 0;
        apply(1, WR, 8'h00, 8'hFF, 0, RV,    8'h00, 1, 0);
        apply(0, WR, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 1);
        apply(0, WR, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        apply(1, ST, 8'hF0, 8'h3C, 0, 8'h00, 8'h30, 1, 0);
        apply(1, TG, 8'hFF, 8'h0F, 0, 8'h00, 8'h3F, 1, 0);
        apply(0, WR, 8'h00, 8'h00, 1, 8'h3F, 8'h3F, 0, 1);
        apply(0, WR, 8'h00, 8'h00, 0, 8'h3F, 8'h3F, 0, 0);
        apply(1, CL, 8'h0F, 8'h03, 0, 8'h3F, 8'h3C, 1, 0);
        apply(1, WR, 8'hC1, 8'hF0, 0, 8'h3F, 8'hCC, 1, 0);
        apply(0, TG, 8'hFF, 8'hFF, 0, 8'h3F, 8'hCC, 1, 0);
        apply(0, WR, 8'h00, 8'h00, 1, 8'hCC, 8'hCC, 0, 1);
        apply(1, WR, 8'h00, 8'h00, 0, 8'hCC, 8'hCC, 1, 0);
        apply(0, WR, 8'h00, 8'h00, 1, 8'hCC, 8'hCC, 0, 0);
        apply(0, WR, 8'h00, 8'h00, 1, 8'hCC, 8'hCC, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o.q !== e.q || o.sh !== e.sh || o.p !== e.p || o.c !== e.c) begin
                n_err++;
                $display("FAIL ops[%0d]: got q=%h sh=%h p=%b c=%b, want q=%h sh=%h p=%b c=%b",
                         i, o.q, o.sh, o.p, o.c, e.q, e.sh, e.p, e.c);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        int i = 0;
        apply(1, WR, 8'h11, 8'hFF, 0, 8'hCC, 8'h11, 1, 0);
        apply(1, WR, 8'h22, 8'hFF, 1, 8'h11, 8'h22, 1, 1);
        apply(0, WR, 8'h00, 8'h00, 1, 8'h22, 8'h22, 0, 1);
        apply(0, WR, 8'h00, 8'h00, 0, 8'h22, 8'h22, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o.q !== e.q || o.sh !== e.sh || o.p !== e.p || o.c !== e.c) begin
                n_err++;
                $display("FAIL b2b[%0d]: got q=%h sh=%h p=%b c=%b, want q=%h sh=%h p=%b c=%b",
                         i, o.q, o.sh, o.p, o.c, e.q, e.sh, e.p, e.c);
            end
            i++;
        end
    endtask

    task automatic test_reset_discard();
        obs_t e, o;
        int i = 0;
        apply(1, WR, 8'h77, 8'hFF, 0, 8'h22, 8'h77, 1, 0);
        mid_reset(1);
        apply(0, WR, 8'h00, 8'h00, 1, RV, RV, 0, 0);
        apply(1, WR, 8'h0F, 8'hFF, 0, RV, 8'h0F, 1, 0);
        apply(0, WR, 8'h00, 8'h00, 1, 8'h0F, 8'h0F, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o.q !== e.q || o.sh !== e.sh || o.p !== e.p || o.c !== e.c) begin
                n_err++;
                $display("FAIL discard[%0d]: got q=%h sh=%h p=%b c=%b, want q=%h sh=%h p=%b c=%b",
                         i, o.q, o.sh, o.p, o.c, e.q, e.sh, e.p, e.c);
            end
            i++;
        end
    endtask

`ifdef N101_REGBANK_PARITY_EN
    task automatic test_parity();
        obs_t e, o;
        logic perr_seen[$];
        logic perr_want[$];
        logic pw, ps;
        int   i = 0;
        n_vec++;
        if (io_perr !== 1'b0) begin
            n_err++;
            $display("FAIL parity_idle: io_perr=%b want 0", io_perr);
        end
        apply(1, WR, 8'h01, 8'hFF, 0, 8'h0F, 8'h01, 1, 0);
        io_perr_inj = 1'b1;
        apply(0, WR, 8'h00, 8'h00, 1, 8'h01, 8'h01, 0, 1);
        io_perr_inj = 1'b0;
        perr_seen.push_back(io_perr); perr_want.push_back(1'b1);
        apply(1, WR, 8'h03, 8'hFF, 0, 8'h01, 8'h03, 1, 0);
        perr_seen.push_back(io_perr); perr_want.push_back(1'b1);
        apply(0, WR, 8'h00, 8'h00, 1, 8'h03, 8'h03, 0, 1);
        perr_seen.push_back(io_perr); perr_want.push_back(1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_vec++;
            if (o.q !== e.q || o.sh !== e.sh || o.p !== e.p || o.c !== e.c) begin
                n_err++;
                $display("FAIL parity_regs[%0d]: got q=%h sh=%h p=%b c=%b, want q=%h sh=%h p=%b c=%b",
                         i, o.q, o.sh, o.p, o.c, e.q, e.sh, e.p, e.c);
            end
            i++;
        end
        i = 0;
        while (perr_want.size() > 0) begin
            pw = perr_want.pop_front(); ps = perr_seen.pop_front(); n_vec++;
            if (ps !== pw) begin
                n_err++;
                $display("FAIL parity[%0d]: io_perr=%b want %b", i, ps, pw);
            end
            i++;
        end
    endtask
`endif

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        test_reset();
        test_ops();
        test_back_to_back();
        test_reset_discard();
`ifdef N101_REGBANK_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/n101_async_reset_reg_bank.md
N101_ASYNC_RESET_REG_BANK -- requirements
Module: n101_async_reset_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the shadow and committed registers; legal range 1..64.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into the shadow and committed registers on reset.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_en  input  1  update request for the shadow register.
REQ-006 io_op  input  2  update operation: 00 write, 01 set, 10 clear, 11 toggle.
REQ-007 io_d  input  WIDTH  operand data.
REQ-008 io_wmask  input  WIDTH  per-bit enable; bits with mask 0 are unaffected.
REQ-009 io_commit  input  1  request to transfer the shadow register into the committed register.
REQ-010 io_q  output  WIDTH  committed register value.
REQ-011 io_shadow  output  WIDTH  shadow register value.
REQ-012 io_pending  output  1  shadow holds an uncommitted update.
REQ-013 io_changed  output  1  one-cycle pulse: the last commit altered io_q.

Function
REQ-014 When io_en=1, the shadow SHALL take, per bit i with io_wmask[i]=1: write d[i]; set s[i]|d[i]; clear s[i]&~d[i]; toggle s[i]^d[i]. Bits with io_wmask[i]=0 SHALL hold.
REQ-015 The shadow SHALL be visible on io_shadow one cycle after the io_en edge; io_en=1 with io_wmask=0 SHALL leave the shadow unchanged but SHALL still set pending.
REQ-016 io_pending SHALL be set on any cycle with io_en=1 and cleared on a commit cycle in which io_en=0.
REQ-017 When io_commit=1 and pending=1, the committed register SHALL load the current shadow value (pre-update), so io_q reflects it one cycle later.
REQ-018 When io_commit=1 and pending=0, the committed register, io_pending and io_changed SHALL be unaffected (io_changed=0).
REQ-019 On simultaneous io_en and io_commit, io_q SHALL receive the pre-update shadow, the shadow SHALL apply the update, and io_pending SHALL remain 1.
REQ-020 io_changed SHALL be registered: high for exactly the cycle after a commit iff the new io_q differs from the old, otherwise 0.
REQ-021 io_q SHALL change only on commit (or reset); io_d/io_op changes without io_en SHALL have no effect.

Reset
REQ-022 On assertion of reset, independent of clock: shadow=RESET_VAL, io_q=RESET_VAL, io_pending=0, io_changed=0, parity state (if present) consistent with RESET_VAL.
REQ-023 Reset mid-operation SHALL discard any uncommitted update; the first rising edge after deassertion SHALL behave as a normal cycle.

Configuration
REQ-024 Macro N101_REGBANK_PARITY_EN defined: the block SHALL add input io_perr_inj (1) and output io_perr (1); a parity bit SHALL be stored alongside the committed register on every commit (inverted if io_perr_inj=1 on that cycle); io_perr SHALL equal XOR(io_q) XOR the stored parity, combinationally; reset leaves io_perr=0.
REQ-025 Macro undefined: io_perr_inj and io_perr SHALL not exist and no parity storage SHALL be built; all other behaviour is identical.

Verification
REQ-026 WIDTH=8, RESET_VAL=8'hA5; assert reset mid-clock -> io_q=io_shadow=8'hA5, io_pending=0, io_changed=0 immediately.
REQ-027 From 8'h00: en op=01 d=8'hF0 mask=8'h3C, next cycle en op=11 d=8'hFF mask=8'h0F, then commit -> io_shadow 8'h30 then 8'h3F; io_q=8'h3F one cycle after commit; io_changed pulses once.
REQ-028 Commit with pending=0 -> io_q holds, io_changed stays 0; commit of a shadow equal to io_q -> io_pending clears, io_changed=0.
REQ-029 shadow=8'h11 pending; same cycle io_en write d=8'h22 mask=8'hFF and io_commit -> io_q=8'h11, io_shadow=8'h22, io_pending=1.
REQ-030 Pending update 8'h77, reset pulsed before commit -> io_q=io_shadow=RESET_VAL, pending=0; a later commit has no effect.
REQ-031 With N101_REGBANK_PARITY_EN: commit 8'h01 with io_perr_inj=1 -> io_perr=1 next cycle; following commit of 8'h03 with inj=0 -> io_perr=0.
